reg_e1of4_scheduler: RTL

- Synchronous controller that shares one QDI e1of4 register between two clocked requesters (A, B).
- Round-robin arbitrates requests and encodes each command as a 1of3 control token (READ, WRITE, READ+WRITE), plus a 1of4 data token for writes.
- Runs the four-phase enable handshakes and decodes the returned 1of4 read token back to binary.
- Sits between the clocked fabric and the async register core; it replaces the behavioural driver and receiver models.

---
 rtl/reg_e1of4_scheduler_pkg.sv | 47 ++++
 rtl/reg_e1of4_scheduler_if.sv | 22 ++
 rtl/reg_e1of4_scheduler_qdi_sync.sv | 27 ++
 rtl/reg_e1of4_scheduler.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_e1of4_scheduler_pkg.sv
// reg_e1of4_pkg
// Shared definitions for the e1of4 register scheduler:
//   - command encoding (READ, WRITE, READ+WRITE, illegal)
//   - scheduler FSM state type
//   - 1of3 / 1of4 rail encode and decode helpers
package reg_e1of4_pkg;

  localparam logic [1:0] CMD_READ    = 2'd0;
  localparam logic [1:0] CMD_WRITE   = 2'd1;
  localparam logic [1:0] CMD_RW      = 2'd2;
  localparam logic [1:0] CMD_ILLEGAL = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_ACK,
    ST_NEUTRAL,
    ST_RXWAIT,
    ST_RXRST,
    ST_DONE
  } state_e;

  // Command to 1of3 control rails; the illegal code maps to neutral.
  function automatic logic [2:0] encode_1of3(input logic [1:0] cmd);
    return (cmd == CMD_ILLEGAL) ? 3'b000 : (3'b001 << cmd);
  endfunction

  function automatic logic [3:0] encode_1of4(input logic [1:0] val);
    return 4'b0001 << val;
  endfunction

  // Index of the lowest high rail, so a multi-hot token still decodes
  // deterministically.
  function automatic logic [1:0] decode_1of4(input logic [3:0] rails);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (rails[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic is_multi_hot4(input logic [3:0] rails);
    return (rails & (rails - 4'd1)) != 4'd0;
  endfunction

endpackage

// File: rtl/reg_e1of4_scheduler_if.sv
// reg_e1of4_scheduler_if
// QDI side of the shared e1of4 register.
//   cx  [2:0]  1of3 control token (all-zero = neutral)
//   cxe        control enable from the core, high = ready
//   tx  [3:0]  1of4 write data token (all-zero = neutral)
//   txe        data enable from the core, high = ready
//   rx  [3:0]  1of4 read token from the core
//   rxe        read enable to the core, high = ready
// master = scheduler, slave = async register core.
interface reg_e1of4_scheduler_if;
  logic [2:0] cx;
  logic       cxe;
  logic [3:0] tx;
  logic       txe;
  logic [3:0] rx;
  logic       rxe;

  modport master (output cx, output tx, output rxe,
                  input  cxe, input txe, input rx);
  modport slave  (input  cx, input tx, input rxe,
                  output cxe, output txe, output rx);
endinterface

// File: rtl/reg_e1of4_scheduler_qdi_sync.sv
// qdi_sync
// Single-bit multi-flop synchronizer for one asynchronous QDI input rail.
//   i_clk     clock
//   i_reset   synchronous active-high reset
//   i_async   asynchronous input bit
//   o_sync    synchronized copy, SYNC_STAGES cycles late
// SYNC_STAGES legal range is 2..4. RESET_VAL is 1 for enables, 0 for data rails.
module qdi_sync #(
  parameter int SYNC_STAGES = 2,
  parameter bit RESET_VAL   = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_sync
);

  logic [SYNC_STAGES-1:0] r_chain;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_chain <= {SYNC_STAGES{RESET_VAL}};
    else         r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
  end

  assign o_sync = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/reg_e1of4_scheduler.sv
// reg_e1of4_scheduler
// Shares one QDI e1of4 register between two clocked requesters A and B.
// Round-robin arbitration, 1of3 control / 1of4 data token issue with
// four-phase handshakes, and 1of4 read token decode.
//   i_clk, i_reset             clock, synchronous active-high reset
//   i_req_a/b                  request level, held until done
//   i_cmd_a/b [1:0]            0=READ 1=WRITE 2=READ+WRITE 3=illegal
//   i_wdata_a/b [DW-1:0]       write data
//   o_gnt_a/b                  high while that requester owns the register
//   o_done_a/b                 one-cycle completion pulse
//   o_rdata [DW-1:0]           read result, valid in the done cycle
//   o_err                      pulses with done for an illegal command
//   o_proto_err                sticky, set on a multi-hot read token
//   qdi                        QDI token/enable bundle (master side)
// Optional macro REG_E1OF4_STATS_EN adds o_tx_count / o_rx_count.
module reg_e1of4_scheduler
  import reg_e1of4_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DW          = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_req_a,
  input  logic                 i_req_b,
  input  logic [1:0]           i_cmd_a,
  input  logic [1:0]           i_cmd_b,
  input  logic [DW-1:0]        i_wdata_a,
  input  logic [DW-1:0]        i_wdata_b,
  output logic                 o_gnt_a,
  output logic                 o_gnt_b,
  output logic                 o_done_a,
  output logic                 o_done_b,
  output logic [DW-1:0]        o_rdata,
  output logic                 o_err,
  output logic                 o_proto_err,
`ifdef REG_E1OF4_STATS_EN
  output logic [15:0]          o_tx_count,
  output logic [15:0]          o_rx_count,
`endif
  reg_e1of4_scheduler_if.master qdi
);

  state_e        r_state, w_state_nxt;
  logic          r_rr, w_rr_nxt;
  logic          r_owner_b, w_owner_b_nxt;
  logic [1:0]    r_cmd, w_cmd_nxt;
  logic [DW-1:0] r_wdata, w_wdata_nxt;
  logic          r_cx_sent, w_cx_sent_nxt;
  logic          r_tx_sent, w_tx_sent_nxt;
  logic [2:0]    r_cx, w_cx_nxt;
  logic [3:0]    r_tx, w_tx_nxt;
  logic          r_rxe, w_rxe_nxt;
  logic          r_gnt_a, w_gnt_a_nxt;
  logic          r_gnt_b, w_gnt_b_nxt;
  logic          r_done_a, w_done_a_nxt;
  logic          r_done_b, w_done_b_nxt;
  logic [DW-1:0] r_rdata, w_rdata_nxt;
  logic          r_err, w_err_nxt;
  logic          r_proto_err, w_proto_err_nxt;
  logic [3:0]    r_rx_prev;

  logic          w_cxe_s;
  logic          w_txe_s;
  logic [3:0]    w_rx_s;
  logic          w_needs_tx;
  logic          w_win_b;
  logic          w_enter_done;

  qdi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cxe (
    .i_clk(i_clk), .i_reset(i_reset), .i_async(qdi.cxe), .o_sync(w_cxe_s)
  );

  qdi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_txe (
    .i_clk(i_clk), .i_reset(i_reset), .i_async(qdi.txe), .o_sync(w_txe_s)
  );

  for (genvar gi = 0; gi < 4; gi++) begin : g_rx_sync
    qdi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_rx (
      .i_clk(i_clk), .i_reset(i_reset), .i_async(qdi.rx[gi]), .o_sync(w_rx_s[gi])
    );
  end

  // Only READ skips the data channel.
  assign w_needs_tx = (r_cmd != CMD_READ);
  // B wins when it is the only requester, or both request and the pointer is at B.
  assign w_win_b    = i_req_b && (!i_req_a || r_rr);

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_rr_nxt        = r_rr;
    w_owner_b_nxt   = r_owner_b;
    w_cmd_nxt       = r_cmd;
    w_wdata_nxt     = r_wdata;
    w_cx_sent_nxt   = r_cx_sent;
    w_tx_sent_nxt   = r_tx_sent;
    w_cx_nxt        = r_cx;
    w_tx_nxt        = r_tx;
    w_rxe_nxt       = r_rxe;
    w_gnt_a_nxt     = r_gnt_a;
    w_gnt_b_nxt     = r_gnt_b;
    w_done_a_nxt    = 1'b0;
    w_done_b_nxt    = 1'b0;
    w_rdata_nxt     = r_rdata;
    w_err_nxt       = 1'b0;
    w_proto_err_nxt = r_proto_err;
    w_enter_done    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (i_req_a || i_req_b) begin
          w_owner_b_nxt = w_win_b;
          if (i_req_a && i_req_b) w_rr_nxt = !w_win_b;
          w_cmd_nxt     = w_win_b ? i_cmd_b : i_cmd_a;
          w_wdata_nxt   = w_win_b ? i_wdata_b : i_wdata_a;
          w_cx_sent_nxt = 1'b0;
          w_tx_sent_nxt = 1'b0;
          // An illegal command completes at once without touching the QDI side.
          if (w_cmd_nxt == CMD_ILLEGAL) begin
            w_err_nxt    = 1'b1;
            w_enter_done = 1'b1;
          end else begin
            w_gnt_a_nxt = !w_win_b;
            w_gnt_b_nxt = w_win_b;
            w_state_nxt = ST_ISSUE;
          end
        end
      end

      // Control and data tokens launch independently as their enables allow.
      ST_ISSUE: begin
        if (!r_cx_sent && w_cxe_s) begin
          w_cx_nxt      = encode_1of3(r_cmd);
          w_cx_sent_nxt = 1'b1;
        end
        if (w_needs_tx && !r_tx_sent && w_txe_s) begin
          w_tx_nxt      = encode_1of4(r_wdata);
          w_tx_sent_nxt = 1'b1;
        end
        if (w_cx_sent_nxt && (!w_needs_tx || w_tx_sent_nxt)) w_state_nxt = ST_ACK;
      end

      ST_ACK: begin
        if (!w_cxe_s && (!w_needs_tx || !w_txe_s)) begin
          w_cx_nxt    = 3'b000;
          w_tx_nxt    = 4'b0000;
          w_state_nxt = ST_NEUTRAL;
        end
      end

      ST_NEUTRAL: begin
        if (w_cxe_s && (!w_needs_tx || w_txe_s)) begin
          if (r_cmd == CMD_WRITE) w_enter_done = 1'b1;
          else                    w_state_nxt  = ST_RXWAIT;
        end
      end

      // Same non-zero value on two consecutive synchronized samples filters
      // rails that are still settling through the synchronizers.
      ST_RXWAIT: begin
        if ((w_rx_s != 4'b0000) && (w_rx_s == r_rx_prev)) begin
          w_rdata_nxt = decode_1of4(w_rx_s);
          if (is_multi_hot4(w_rx_s)) w_proto_err_nxt = 1'b1;
          w_rxe_nxt   = 1'b0;
          w_state_nxt = ST_RXRST;
        end
      end

      ST_RXRST: begin
        if (w_rx_s == 4'b0000) begin
          w_rxe_nxt    = 1'b1;
          w_enter_done = 1'b1;
        end
      end

      ST_DONE: w_state_nxt = ST_IDLE;

      default: w_state_nxt = ST_IDLE;
    endcase

    // Done and grant-drop are registered together so they land in the DONE cycle.
    if (w_enter_done) begin
      w_state_nxt  = ST_DONE;
      w_gnt_a_nxt  = 1'b0;
      w_gnt_b_nxt  = 1'b0;
      w_done_a_nxt = !w_owner_b_nxt;
      w_done_b_nxt = w_owner_b_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rr        <= 1'b0;
      r_owner_b   <= 1'b0;
      r_cmd       <= CMD_READ;
      r_wdata     <= '0;
      r_cx_sent   <= 1'b0;
      r_tx_sent   <= 1'b0;
      r_cx        <= 3'b000;
      r_tx        <= 4'b0000;
      r_rxe       <= 1'b1;
      r_gnt_a     <= 1'b0;
      r_gnt_b     <= 1'b0;
      r_done_a    <= 1'b0;
      r_done_b    <= 1'b0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_proto_err <= 1'b0;
      r_rx_prev   <= 4'b0000;
    end else begin
      r_rr        <= w_rr_nxt;
      r_owner_b   <= w_owner_b_nxt;
      r_cmd       <= w_cmd_nxt;
      r_wdata     <= w_wdata_nxt;
      r_cx_sent   <= w_cx_sent_nxt;
      r_tx_sent   <= w_tx_sent_nxt;
      r_cx        <= w_cx_nxt;
      r_tx        <= w_tx_nxt;
      r_rxe       <= w_rxe_nxt;
      r_gnt_a     <= w_gnt_a_nxt;
      r_gnt_b     <= w_gnt_b_nxt;
      r_done_a    <= w_done_a_nxt;
      r_done_b    <= w_done_b_nxt;
      r_rdata     <= w_rdata_nxt;
      r_err       <= w_err_nxt;
      r_proto_err <= w_proto_err_nxt;
      r_rx_prev   <= w_rx_s;
    end
  end

`ifdef REG_E1OF4_STATS_EN
  logic [15:0] r_tx_count;
  logic [15:0] r_rx_count;

  // A control handshake counts once its enable has returned high (NEUTRAL exit).
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_tx_count <= 16'd0;
      r_rx_count <= 16'd0;
    end else begin
      if ((r_state == ST_NEUTRAL) && (w_state_nxt != ST_NEUTRAL)) r_tx_count <= r_tx_count + 16'd1;
      if ((r_state == ST_RXWAIT) && (w_state_nxt == ST_RXRST))    r_rx_count <= r_rx_count + 16'd1;
    end
  end

  assign o_tx_count = r_tx_count;
  assign o_rx_count = r_rx_count;
`endif

  assign qdi.cx      = r_cx;
  assign qdi.tx      = r_tx;
  assign qdi.rxe     = r_rxe;
  assign o_gnt_a     = r_gnt_a;
  assign o_gnt_b     = r_gnt_b;
  assign o_done_a    = r_done_a;
  assign o_done_b    = r_done_b;
  assign o_rdata     = r_rdata;
  assign o_err       = r_err;
  assign o_proto_err = r_proto_err;

endmodule
